// File: rtl/lever_conditioner.sv
// Lever input conditioner: two-flop synchroniser, counter-based debounce FSM,
// registered pull/reject/long-hold strobes and a wrapping accepted-pull counter.
module lever_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int HOLD_CYCLES     = 200,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lever,
    input  logic       spin_busy,
    output logic       lever_level,
    output logic       pull_pulse,
    output logic       pull_rejected,
    output logic       long_pull,
    output logic [7:0] pull_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_CYCLES - 2);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= lever;
            s2 <= s1;
        end
    end

    // Strobes default low every cycle; each state only raises the one it owns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            lever_level   <= 1'b0;
            pull_pulse    <= 1'b0;
            pull_rejected <= 1'b0;
            long_pull     <= 1'b0;
            pull_count    <= 8'd0;
        end else begin
            pull_pulse    <= 1'b0;
            pull_rejected <= 1'b0;
            long_pull     <= 1'b0;
            case (state)
                IDLE: begin
                    lever_level <= 1'b0;
                    if (s2) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        deb_cnt     <= '0;
                        lever_level <= 1'b1;
                        hold_cnt    <= '0;
                        if (spin_busy) begin
                            pull_rejected <= 1'b1;
                        end else begin
                            pull_pulse <= 1'b1;
                            pull_count <= pull_count + 8'd1;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    // The hold count only ever crosses HOLD_CYCLES-1 once per press,
                    // so long_pull cannot re-fire after a release bounce.
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                        if (hold_cnt == HOLD_PRE) begin
                            long_pull <= 1'b1;
                        end
                    end
                    if (!s2) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= IDLE;
                        deb_cnt     <= '0;
                        lever_level <= 1'b0;
                        hold_cnt    <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lever_conditioner.sv
// Self-checking bench for lever_conditioner: directed scenarios with fixed timing
// expectations plus randomized lever/spin_busy traffic against a sample-window model.
module tb_lever_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lever = 1'b0;
    logic       spin_busy = 1'b0;
    logic       lever_level;
    logic       pull_pulse;
    logic       pull_rejected;
    logic       long_pull;
    logic [7:0] pull_count;

    int n_compared = 0;
    int n_failed   = 0;

    always #5 clk = ~clk;

    lever_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lever        (lever),
        .spin_busy    (spin_busy),
        .lever_level  (lever_level),
        .pull_pulse   (pull_pulse),
        .pull_rejected(pull_rejected),
        .long_pull    (long_pull),
        .pull_count   (pull_count)
    );

    // Reference: the debounced level flips once the last DEB synchronised samples agree.
    logic [1:0]     m_sync;
    logic [DEB-1:0] m_hist;
    logic           exp_level;
    logic           exp_pulse;
    logic           exp_rej;
    logic [7:0]     exp_count;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sync    = 2'b00;
            m_hist    = '0;
            exp_level = 1'b0;
            exp_pulse = 1'b0;
            exp_rej   = 1'b0;
            exp_count = 8'd0;
        end else begin
            m_hist    = {m_hist[DEB-2:0], m_sync[1]};
            m_sync    = {m_sync[0], lever};
            exp_pulse = 1'b0;
            exp_rej   = 1'b0;
            if (!exp_level && (&m_hist)) begin
                exp_level = 1'b1;
                if (spin_busy) begin
                    exp_rej = 1'b1;
                end else begin
                    exp_pulse = 1'b1;
                    exp_count = exp_count + 8'd1;
                end
            end else if (exp_level && (m_hist == '0)) begin
                exp_level = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        lever = 1'b1;
        spin_busy = 1'b0;
        repeat (4) @(negedge clk);
        n_compared++;
        if (lever_level !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_level: got %b expected 0", lever_level); end
        n_compared++;
        if (pull_pulse !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_pulse: got %b expected 0", pull_pulse); end
        n_compared++;
        if (pull_rejected !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_rejected: got %b expected 0", pull_rejected); end
        n_compared++;
        if (long_pull !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_long: got %b expected 0", long_pull); end
        n_compared++;
        if (pull_count !== 8'd0) begin n_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", pull_count); end
        lever = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_clean_pull();
        int pulses = 0, longs = 0, rejs = 0, pulse_k = -1, long_k = -1;
        spin_busy = 1'b0;
        lever = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (pull_pulse) begin pulses++; pulse_k = k; end
            if (long_pull) begin longs++; long_k = k; end
            if (pull_rejected) rejs++;
            if (k == 5 || k == 36) begin
                n_compared++;
                if (lever_level !== 1'b0) begin n_failed++; $display("[TB] FAIL clean_level_low_k%0d: got %b expected 0", k, lever_level); end
            end
            if (k == 6 || k == 35) begin
                n_compared++;
                if (lever_level !== 1'b1) begin n_failed++; $display("[TB] FAIL clean_level_high_k%0d: got %b expected 1", k, lever_level); end
            end
            if (k == 30) lever = 1'b0;
        end
        n_compared++;
        if (pulses !== 1) begin n_failed++; $display("[TB] FAIL clean_pulse_count: got %0d expected 1", pulses); end
        n_compared++;
        if (pulse_k !== 6) begin n_failed++; $display("[TB] FAIL clean_pulse_latency: got %0d expected 6", pulse_k); end
        n_compared++;
        if (longs !== 1) begin n_failed++; $display("[TB] FAIL clean_long_count: got %0d expected 1", longs); end
        n_compared++;
        if (long_k !== pulse_k + HOLD - 1) begin n_failed++; $display("[TB] FAIL clean_long_timing: got %0d expected %0d", long_k, pulse_k + HOLD - 1); end
        n_compared++;
        if (rejs !== 0) begin n_failed++; $display("[TB] FAIL clean_rejects: got %0d expected 0", rejs); end
        n_compared++;
        if (pull_count !== 8'd1) begin n_failed++; $display("[TB] FAIL clean_count: got %0d expected 1", pull_count); end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b01101;
        int strobes = 0, highs = 0;
        for (int i = 0; i < 20; i++) begin
            lever = (i < 5) ? pat[i] : 1'b0;
            @(negedge clk);
            if (pull_pulse || pull_rejected || long_pull) strobes++;
            if (lever_level) highs++;
        end
        n_compared++;
        if (strobes !== 0) begin n_failed++; $display("[TB] FAIL bounce_strobes: got %0d expected 0", strobes); end
        n_compared++;
        if (highs !== 0) begin n_failed++; $display("[TB] FAIL bounce_level: got %0d high cycles expected 0", highs); end
        n_compared++;
        if (pull_count !== 8'd1) begin n_failed++; $display("[TB] FAIL bounce_count: got %0d expected 1", pull_count); end
    endtask

    task automatic test_busy_reject();
        int pulses = 0, rejs = 0, rej_k = -1;
        spin_busy = 1'b1;
        lever = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (pull_pulse) pulses++;
            if (pull_rejected) begin rejs++; rej_k = k; end
            if (k == 6) begin
                n_compared++;
                if (lever_level !== 1'b1) begin n_failed++; $display("[TB] FAIL busy_level: got %b expected 1", lever_level); end
            end
            if (k == 10) lever = 1'b0;
        end
        spin_busy = 1'b0;
        n_compared++;
        if (rejs !== 1) begin n_failed++; $display("[TB] FAIL busy_reject_count: got %0d expected 1", rejs); end
        n_compared++;
        if (rej_k !== 6) begin n_failed++; $display("[TB] FAIL busy_reject_latency: got %0d expected 6", rej_k); end
        n_compared++;
        if (pulses !== 0) begin n_failed++; $display("[TB] FAIL busy_pulses: got %0d expected 0", pulses); end
        n_compared++;
        if (pull_count !== 8'd1) begin n_failed++; $display("[TB] FAIL busy_count: got %0d expected 1", pull_count); end
    endtask

    task automatic test_release_bounce();
        int pulses = 0, rejs = 0, longs = 0, lows = 0;
        spin_busy = 1'b0;
        lever = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (pull_pulse) pulses++;
            if (pull_rejected) rejs++;
            if (long_pull) longs++;
            if (k >= 6 && k <= 31 && !lever_level) lows++;
            if (k == 32) begin
                n_compared++;
                if (lever_level !== 1'b0) begin n_failed++; $display("[TB] FAIL rbounce_final_level: got %b expected 0", lever_level); end
            end
            if (k == 14) lever = 1'b0;
            if (k == 16) lever = 1'b1;
            if (k == 26) lever = 1'b0;
        end
        n_compared++;
        if (lows !== 0) begin n_failed++; $display("[TB] FAIL rbounce_level_drop: got %0d low cycles expected 0", lows); end
        n_compared++;
        if (pulses !== 1) begin n_failed++; $display("[TB] FAIL rbounce_pulses: got %0d expected 1", pulses); end
        n_compared++;
        if (rejs !== 0) begin n_failed++; $display("[TB] FAIL rbounce_rejects: got %0d expected 0", rejs); end
        n_compared++;
        if (longs !== 1) begin n_failed++; $display("[TB] FAIL rbounce_long: got %0d expected 1", longs); end
        n_compared++;
        if (pull_count !== 8'd2) begin n_failed++; $display("[TB] FAIL rbounce_count: got %0d expected 2", pull_count); end
    endtask

    task automatic test_random();
        int remaining = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n_compared++;
            if (lever_level !== exp_level) begin n_failed++; $display("[TB] FAIL rand_level c%0d: got %b expected %b", c, lever_level, exp_level); end
            n_compared++;
            if (pull_pulse !== exp_pulse) begin n_failed++; $display("[TB] FAIL rand_pulse c%0d: got %b expected %b", c, pull_pulse, exp_pulse); end
            n_compared++;
            if (pull_rejected !== exp_rej) begin n_failed++; $display("[TB] FAIL rand_rejected c%0d: got %b expected %b", c, pull_rejected, exp_rej); end
            n_compared++;
            if (pull_count !== exp_count) begin n_failed++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, pull_count, exp_count); end
            if (remaining == 0) begin
                lever = ~lever;
                remaining = $urandom_range(1, 8);
            end
            remaining--;
            if ($urandom_range(0, 7) == 0) spin_busy = ~spin_busy;
        end
        lever = 1'b0;
        spin_busy = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_wrap_reset();
        int pulses = 0, pulse_k = -1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 256; p++) begin
            lever = 1'b1;
            repeat (8) @(negedge clk);
            lever = 1'b0;
            repeat (8) @(negedge clk);
        end
        n_compared++;
        if (pull_count !== 8'd0) begin n_failed++; $display("[TB] FAIL wrap_count: got %0d expected 0", pull_count); end
        lever = 1'b1;
        repeat (8) @(negedge clk);
        lever = 1'b0;
        repeat (8) @(negedge clk);
        n_compared++;
        if (pull_count !== 8'd1) begin n_failed++; $display("[TB] FAIL wrap_plus_one: got %0d expected 1", pull_count); end
        lever = 1'b1;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        n_compared++;
        if (pull_count !== 8'd0) begin n_failed++; $display("[TB] FAIL midreset_count: got %0d expected 0", pull_count); end
        n_compared++;
        if ({lever_level, pull_pulse, pull_rejected, long_pull} !== 4'b0000) begin
            n_failed++;
            $display("[TB] FAIL midreset_outputs: got %b expected 0000", {lever_level, pull_pulse, pull_rejected, long_pull});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pull_pulse) begin pulses++; pulse_k = k; end
        end
        n_compared++;
        if (pulses !== 1) begin n_failed++; $display("[TB] FAIL held_release_pulses: got %0d expected 1", pulses); end
        n_compared++;
        if (pulse_k !== DEB + 2) begin n_failed++; $display("[TB] FAIL held_release_latency: got %0d expected %0d", pulse_k, DEB + 2); end
        n_compared++;
        if (pull_count !== 8'd1) begin n_failed++; $display("[TB] FAIL held_release_count: got %0d expected 1", pull_count); end
        lever = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        $display("[TB] lever_conditioner bench start");
        test_reset();
        test_clean_pull();
        test_bounce();
        test_busy_reject();
        test_release_bounce();
        test_random();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
